// File: rtl/rle_word_prefetch.sv
// rle_word_prefetch: prefetch FIFO between the SPI flash read controller and the
// RLE decoder. Keeps a DEPTH-entry FIFO of 16-bit words topped up through the
// controller's start/continue/stop handshake, hiding flash latency from the
// pixel-rate consumer. Supports frame restart and mark/rewind of the fetch address.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   frame_start, mark, rewind control pulses (flush to 0, record head, flush to mark)
//   spi_addr                  word address presented with spi_start_read
//   spi_start_read/continue/stop  1-cycle request pulses to the controller
//   spi_busy, spi_data        controller status and returned word
//   out_valid, out_data       registered FIFO head
//   out_ready                 consumer pop
//   level                     FIFO occupancy
module rle_word_prefetch #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   mark,
  input  logic                   rewind,
  output logic [ADDR_BITS-1:0]   spi_addr,
  output logic                   spi_start_read,
  output logic                   spi_continue_read,
  output logic                   spi_stop_read,
  input  logic                   spi_busy,
  input  logic [15:0]            spi_data,
  output logic                   out_valid,
  output logic [15:0]            out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t               state;
  logic                 wait_first;
  logic [ADDR_BITS-1:0] fetch_addr;
  logic [ADDR_BITS-1:0] mark_addr;
  logic [15:0]          mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;

  logic          flush;
  logic          space;
  logic          pop;
  logic          push;
  logic [PW-1:0] rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [15:0]   head_n;

  assign level = count;

  // Per-cycle FIFO events and the head word to register for next cycle
  always_comb begin
    flush    = frame_start | rewind;
    space    = count < CW'(DEPTH);
    pop      = out_ready && (count != '0) && !flush;
    // The first WAIT cycle sees a stale busy from before the request landed
    push     = (state == WAIT) && !wait_first && !spi_busy && !flush;
    rd_ptr_n = rd_ptr + PW'(pop);
    count_n  = count + CW'(push) - CW'(pop);
    head_n   = mem[rd_ptr_n];
    if (count_n == '0) begin
      head_n = '0;
    end else if (count == CW'(pop)) begin
      // Nothing stored survives this cycle, so the incoming word becomes head
      head_n = spi_data;
    end
  end

  // FIFO storage (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= spi_data;
    end
  end

  // Read-handshake FSM, fetch/mark addresses and registered FIFO outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wait_first        <= 1'b0;
      fetch_addr        <= '0;
      mark_addr         <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      spi_addr          <= '0;
      spi_start_read    <= 1'b0;
      spi_continue_read <= 1'b0;
      spi_stop_read     <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
    end else begin
      spi_start_read    <= 1'b0;
      spi_continue_read <= 1'b0;
      spi_stop_read     <= 1'b0;
      wait_first        <= 1'b0;
      if (flush) begin
        spi_stop_read <= (state != IDLE);
        state         <= IDLE;
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        count         <= '0;
        out_valid     <= 1'b0;
        out_data      <= '0;
        fetch_addr    <= frame_start ? '0 : mark_addr;
      end else begin
        // Head word address = next fetch address minus words already buffered
        if (mark) begin
          mark_addr <= fetch_addr - ADDR_BITS'(count);
        end
        rd_ptr    <= rd_ptr_n;
        count     <= count_n;
        out_valid <= (count_n != '0);
        out_data  <= head_n;
        if (push) begin
          wr_ptr     <= wr_ptr + PW'(1);
          fetch_addr <= fetch_addr + ADDR_BITS'(1);
        end
        case (state)
          IDLE: begin
            if (space) begin
              spi_start_read <= 1'b1;
              spi_addr       <= fetch_addr;
              wait_first     <= 1'b1;
              state          <= WAIT;
            end
          end
          STREAM: begin
            // Read stays open while full; no stop is issued here
            if (space) begin
              spi_continue_read <= 1'b1;
              wait_first        <= 1'b1;
              state             <= WAIT;
            end
          end
          WAIT: begin
            if (push) begin
              state <= STREAM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rle_word_prefetch.sv
// Testbench for rle_word_prefetch: a flash controller model answers requests
// after a programmable latency with a fixed address->word mapping, and a
// behavioural model tracks the next address the consumer must see, the FIFO
// occupancy, the marked address and whether a read is open.
module tb_rle_word_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AB    = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          mark;
  logic          rewind;
  logic [AB-1:0] spi_addr;
  logic          spi_start_read;
  logic          spi_continue_read;
  logic          spi_stop_read;
  logic          spi_busy = 1'b0;
  logic [15:0]   spi_data = '0;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_ready;
  logic [LW-1:0] level;

  rle_word_prefetch #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk               (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .mark              (mark),
    .rewind            (rewind),
    .spi_addr          (spi_addr),
    .spi_start_read    (spi_start_read),
    .spi_continue_read (spi_continue_read),
    .spi_stop_read     (spi_stop_read),
    .spi_busy          (spi_busy),
    .spi_data          (spi_data),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ready         (out_ready),
    .level             (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Flash content: distinct word per address so misordering is visible in all bits
  function automatic logic [15:0] word_of(input logic [AB-1:0] a);
    return (16'(a) * 16'h1357) ^ 16'hA5C3;
  endfunction

  // Flash controller model
  int            lat = 4;
  logic [AB-1:0] c_addr = '0;
  int            c_cnt = 0;
  bit            c_pend = 0;
  bit            deliv = 0;

  always @(negedge clk) begin
    deliv = 0;
    if (rst) begin
      c_pend   = 0;
      spi_busy = 1'b0;
    end else if (spi_stop_read) begin
      c_pend   = 0;
      spi_busy = 1'b0;
    end else if (spi_start_read || spi_continue_read) begin
      c_addr   = spi_start_read ? spi_addr : c_addr + 1'b1;
      c_cnt    = lat;
      c_pend   = 1;
      spi_busy = 1'b1;
    end else if (c_pend) begin
      c_cnt--;
      if (c_cnt == 0) begin
        c_pend   = 0;
        spi_busy = 1'b0;
        spi_data = word_of(c_addr);
        deliv    = 1;
      end
    end
  end

  // Reference model state
  int            errors = 0;
  int            checks = 0;
  int            m_cnt = 0;
  logic [AB-1:0] m_head = '0;
  logic [AB-1:0] m_mark = '0;
  bit            m_open = 0;
  bit            p_valid = 0;
  logic [15:0]   p_data = '0;
  int            n_start = 0;
  int            n_cont = 0;
  int            n_stop = 0;
  int            n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model for the edge just taken and compare outputs
  task automatic step();
    bit flush;
    bit exp_stop;
    flush = frame_start | rewind;
    @(posedge clk);
    #1;
    exp_stop = flush && m_open;
    if (flush) begin
      m_cnt  = 0;
      m_head = frame_start ? '0 : m_mark;
      m_open = 0;
    end else begin
      if (mark) m_mark = m_head;
      if (out_ready && m_cnt > 0) begin
        chk("pop_data", 32'(p_data), 32'(word_of(m_head)));
        m_head = m_head + 1'b1;
        m_cnt--;
        n_pop++;
      end
      if (deliv) m_cnt++;
    end
    chk("level", 32'(level), 32'(m_cnt));
    chk("out_valid", 32'(out_valid), 32'(m_cnt > 0));
    chk("stop", 32'(spi_stop_read), 32'(exp_stop));
    chk("one_pulse", 32'($countones({spi_start_read, spi_continue_read, spi_stop_read}) <= 1), 32'd1);
    if (spi_start_read) begin
      n_start++;
      chk("start_addr", 32'(spi_addr), 32'(m_head));
      chk("start_closed", 32'(m_open), 32'd0);
      chk("start_room", 32'(m_cnt < DEPTH), 32'd1);
      m_open = 1;
    end
    if (spi_continue_read) begin
      n_cont++;
      chk("cont_open", 32'(m_open), 32'd1);
      chk("cont_room", 32'(m_cnt < DEPTH), 32'd1);
    end
    if (spi_stop_read) n_stop++;
    p_valid = out_valid;
    p_data  = out_data;
  endtask

  task automatic run_until_start(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = spi_start_read;
    end
    chk({tag, "_start_seen"}, 32'(found), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_start"}, 32'(spi_start_read), 32'd0);
    chk({tag, "_cont"}, 32'(spi_continue_read), 32'd0);
    chk({tag, "_stop"}, 32'(spi_stop_read), 32'd0);
    chk({tag, "_addr"}, 32'(spi_addr), 32'd0);
  endtask

  initial begin
    int base;
    bit found;
    rst = 1'b1; frame_start = 1'b0; mark = 1'b0; rewind = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    p_valid = out_valid;
    p_data  = out_data;

    // Fill with consumer stalled: one start at 0, three continues, then hold
    repeat (40) step();
    chk("fill_starts", 32'(n_start), 32'd1);
    chk("fill_conts", 32'(n_cont), 32'd3);
    chk("fill_level", 32'(level), 32'(DEPTH));
    chk("fill_stops", 32'(n_stop), 32'd0);

    // Free-running consumer: in-order stream, one request per word consumed
    out_ready = 1'b1;
    repeat (60) step();
    out_ready = 1'b0;
    chk("stream_pops", 32'(n_pop >= 8), 32'd1);
    base = (n_start + n_cont) - (n_pop + m_cnt);
    chk("req_balance", 32'(base == 0 || base == 1), 32'd1);

    // mark at word 5, consume 3, rewind back to 5
    frame_start = 1'b1; step(); frame_start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && m_head != AB'(5); i++) step();
    out_ready = 1'b0;
    for (int i = 0; i < 100 && m_cnt < DEPTH; i++) step();
    chk("mark_head", 32'(out_data), 32'(word_of(AB'(5))));
    mark = 1'b1; step(); mark = 1'b0;
    base = n_pop;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && n_pop < base + 3; i++) step();
    out_ready = 1'b0;
    chk("pop3", 32'(n_pop - base), 32'd3);
    rewind = 1'b1; step(); rewind = 1'b0;
    chk("rewind_stop", 32'(spi_stop_read), 32'd1);
    chk("rewind_level", 32'(level), 32'd0);
    run_until_start("rewind");
    chk("rewind_addr", 32'(spi_addr), 32'd5);
    for (int i = 0; i < 50 && !out_valid; i++) step();
    chk("rewind_first", 32'(out_data), 32'(word_of(AB'(5))));

    // frame_start exactly when busy falls: word is dropped
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = c_pend && (c_cnt == 1);
    end
    chk("drop_setup", 32'(found), 32'd1);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("drop_stop", 32'(spi_stop_read), 32'd1);
    chk("drop_level", 32'(level), 32'd0);
    run_until_start("drop");
    chk("drop_addr", 32'(spi_addr), 32'd0);
    repeat (10) step();
    frame_start = 1'b1; rewind = 1'b1; step(); frame_start = 1'b0; rewind = 1'b0;
    run_until_start("both");
    chk("both_addr", 32'(spi_addr), 32'd0);

    // Address wrap: mark with head 14 and four buffered (fetch already wrapped)
    out_ready = 1'b1;
    for (int i = 0; i < 400 && m_head != AB'(14); i++) step();
    out_ready = 1'b0;
    for (int i = 0; i < 100 && m_cnt < DEPTH; i++) step();
    chk("wrap_full", 32'(level), 32'(DEPTH));
    mark = 1'b1; step(); mark = 1'b0;
    rewind = 1'b1; step(); rewind = 1'b0;
    run_until_start("wrap");
    chk("wrap_mark_addr", 32'(spi_addr), 32'd14);
    out_ready = 1'b1;
    repeat (60) step();
    out_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      lat         = $urandom_range(1, 6);
      out_ready   = ($urandom_range(0, 3) != 0);
      mark        = ($urandom_range(0, 15) == 0);
      frame_start = ($urandom_range(0, 79) == 0);
      rewind      = ($urandom_range(0, 59) == 0);
      step();
    end
    lat = 4; out_ready = 1'b0; mark = 1'b0; frame_start = 1'b0; rewind = 1'b0;

    // Async reset mid-read with two words buffered
    rewind = 1'b1; step(); rewind = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = (m_cnt == 2) && c_pend;
    end
    chk("rst_setup", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    m_cnt = 0; m_head = '0; m_mark = '0; m_open = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p_valid = out_valid;
    p_data  = out_data;
    run_until_start("post_rst");
    chk("post_rst_addr", 32'(spi_addr), 32'd0);
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
